// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: req/gnt request phase, rvalid read-data phase.
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-enable / store-lane replication and load lane extract with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        ld_sx;

  assign ld_b  = ld_word[{ld_off, 3'b000} +: 8];
  assign ld_h  = ld_word[{ld_off[1], 4'b0000} +: 16];
  assign ld_sx = ~ld_funct3[2];

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    unique case (1'b1)
      st_funct3 inside {F3_LB, F3_LBU}: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      st_funct3 inside {F3_LH, F3_LHU}: begin
        be    = 4'b0011 << {st_off[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    unique case (1'b1)
      ld_funct3 inside {F3_LB, F3_LBU}:
        ld_data = {{24{ld_b[7] & ld_sx}}, ld_b};
      ld_funct3 inside {F3_LH, F3_LHU}:
        ld_data = {{16{ld_h[15] & ld_sx}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage on a req/gnt/rvalid bus, with timeout.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_is_store,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               stall,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic               bus_err,
  output logic               misalign,
  load_store_unit_if.master  mem
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q;
  lsu_state_t  state_d;
  logic [15:0] cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data;
  logic        accept;
  logic        trap;
  logic        expired;
  logic        fin_err;
  logic        done;

  lsu_align u_align (
    .st_funct3 (req_funct3),
    .st_off    (req_addr[1:0]),
    .st_data   (req_wdata),
    .be        (be_d),
    .wdata     (wdata_d),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  assign accept  = (state_q == IDLE) & req_valid;
  assign expired = (cnt_q == CNT_LAST);
  assign done    = (state_q == DONE);

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  always_comb begin
    trap = 1'b0;
    unique case (1'b1)
      req_funct3 inside {F3_LB, F3_LBU}:
        trap = 1'b0;
      req_funct3 inside {F3_LH, F3_LHU}:
        trap = req_addr[0];
      default:
        trap = |req_addr[1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= trap;
    end
  end

  assign misalign = done & mis_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // A store completes on gnt; a gnt arriving on the last
  // budgeted cycle of a load still counts as a timeout.
  always_comb begin
    state_d = state_q;
    fin_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = trap ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem.mem_gnt && we_q) begin
          state_d = DONE;
        end else if (expired) begin
          state_d = DONE;
          fin_err = 1'b1;
        end else if (mem.mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = DONE;
        end else if (expired) begin
          state_d = DONE;
          fin_err = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        we_q    <= req_is_store;
        addr_q  <= {req_addr[31:2], 2'b00};
        off_q   <= req_addr[1:0];
        be_q    <= be_d;
        wdata_q <= wdata_d;
        f3_q    <= req_funct3;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (fin_err) begin
        err_q <= 1'b1;
      end
      if (state_q == WAIT && mem.mem_rvalid) begin
        rdata_q <= ld_data;
      end
    end
  end

  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign stall       = req_valid & ~done;
  assign rdata       = rdata_q;
  assign rdata_valid = done & ~we_q & ~err_q & ~misalign;
  assign bus_err     = done & err_q;

endmodule
